// File: rtl/shift_reg_var.sv
// rtl/shift_reg_var.sv - runtime-programmable multi-channel delay line
//
// Delays CHANNELS packed lanes of WIDTH bits, plus a valid qualifier, by a
// run-time selectable number of enabled clock cycles (0 .. MAX_DEPTH).
// A two-state priming machine (FILL, RUN) keeps dout_valid low until the
// history behind the read pointer belongs to the current depth setting.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   ena         clock enable; only an enabled edge advances anything
//   depth       requested delay in enabled cycles (clamped to MAX_DEPTH)
//   din         input lanes, lane n at [n*WIDTH +: WIDTH]
//   din_valid   qualifier travelling with din
//   dout        delayed lanes (combinational pass-through at depth 0)
//   dout_valid  delayed din_valid, gated by primed
//   primed      history at the current depth is genuine
//   depth_err   sticky: an out-of-range depth was sampled

module shift_reg_var #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int MAX_DEPTH = 64,
    // Derived width of the depth port; leave at its default.
    parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [DW-1:0]             depth,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      din_valid,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic                      primed,
    output logic                      depth_err
);

    localparam int DATA_W = CHANNELS * WIDTH;
    localparam int ENT_W  = DATA_W + 1;
    localparam int PW     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    // One extra bit over DW so wr_ptr + MAX_DEPTH + 1 - depth never overflows.
    localparam int AW     = DW + 1;

    localparam logic [DW-1:0] MAX_D    = DW'(MAX_DEPTH);
    localparam logic [AW-1:0] MAX_A    = AW'(MAX_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_DEPTH - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       fcnt_q, fcnt_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic                init_q, init_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dv_q, dv_d;

    logic [ENT_W-1:0]    mem_q [MAX_DEPTH];

    logic                depth_over;
    logic [DW-1:0]       depth_s;
    logic                depth_chg;
    logic [DW-1:0]       rd_dep;
    logic [AW-1:0]       rd_sum;
    logic [PW-1:0]       rd_addr;
    logic [ENT_W-1:0]    rd_ent;
    logic                pass;

    // ------------------------------------------------------------------
    // Depth sampling and clamping
    // ------------------------------------------------------------------
    always_comb begin
        depth_over = (depth > MAX_D);
        depth_s    = depth_over ? MAX_D : depth;
        depth_d    = ena ? depth_s : depth_q;
    end

    // ------------------------------------------------------------------
    // Write pointer
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (ena) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read side. The depth sampled on this edge selects the entry, so the
    // new setting takes effect on the same edge that loads it. Depth 1
    // needs the sample being written right now, so it bypasses the RAM;
    // at MAX_DEPTH the read lands one slot ahead of the write and never
    // collides with it.
    // ------------------------------------------------------------------
    always_comb begin
        rd_dep  = (depth_s == '0) ? DW'(1) : depth_s;
        rd_sum  = AW'(wr_ptr_q) + MAX_A + AW'(1) - AW'(rd_dep);
        rd_addr = (rd_sum >= MAX_A) ? PW'(rd_sum - MAX_A) : PW'(rd_sum);
        if (rd_dep == DW'(1)) begin
            rd_ent = {din_valid, din};
        end else begin
            rd_ent = mem_q[rd_addr];
        end
    end

    always_comb begin
        dout_d = dout_q;
        dv_d   = dv_q;
        if (ena) begin
            dout_d = rd_ent[DATA_W-1:0];
            dv_d   = rd_ent[DATA_W];
        end
    end

    // ------------------------------------------------------------------
    // Priming FSM. The first enabled edge after reset loads the depth
    // without counting as a change: reset already invalidated the history,
    // so that edge is the first genuine sample and counts toward priming.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        init_d    = init_q;
        err_d     = err_q;
        depth_chg = (depth_s != depth_q) && !init_q;
        if (ena) begin
            init_d = 1'b0;
            if (depth_over) begin
                err_d = 1'b1;
            end
            if (depth_s == '0) begin
                state_d = S_RUN;
                fcnt_d  = '0;
            end else if (depth_chg) begin
                state_d = S_FILL;
                fcnt_d  = '0;
            end else if (state_q == S_FILL) begin
                if (fcnt_q == depth_s - DW'(1)) begin
                    state_d = S_RUN;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d  = fcnt_q + DW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FILL;
            fcnt_q   <= '0;
            depth_q  <= '0;
            wr_ptr_q <= '0;
            init_q   <= 1'b1;
            err_q    <= 1'b0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            depth_q  <= depth_d;
            wr_ptr_q <= wr_ptr_d;
            init_q   <= init_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
        end
    end

    // Buffer contents are not reset; FILL gating hides stale entries.
    always_ff @(posedge clk) begin
        if (ena) begin
            mem_q[wr_ptr_q] <= {din_valid, din};
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Pass-through requires RUN so that the reset state (depth_q
    // is 0 there too) still presents zeros.
    // ------------------------------------------------------------------
    always_comb begin
        pass       = (depth_q == '0) && (state_q == S_RUN);
        primed     = (state_q == S_RUN);
        depth_err  = err_q;
        dout       = pass ? din : dout_q;
        dout_valid = pass ? din_valid : (dv_q && (state_q == S_RUN));
    end

endmodule
